md_unit: RTL and testbench

- Parametrised multiply/divide unit with HI/LO registers for the P7-generation pipelined MIPS core; sits in the E stage beside the ALU.
- Executes mult/multu/div/divu over a configurable number of cycles, and handles mthi/mtlo.
- Exposes HI/LO to mfhi/mflo and drives a stall request for any D-stage HI/LO-related instruction while busy.
- Adds a flush/abort path for exception cancellation.

---
 rtl/md_pkg.sv | 21 ++
 rtl/md_divider.sv | 40 ++++
 rtl/md_unit.sv | 95 +++++++++
 tb/tb_md_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and
// the default datapath width.
package md_pkg;

  localparam int MD_W = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  function automatic logic is_arith(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_divider.sv
// Combinational signed/unsigned divider. Quotient truncates toward zero and
// the remainder takes the dividend's sign; a zero divisor is flagged.
module md_divider
  import md_pkg::*;
#(
  parameter int WIDTH = MD_W
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  // Magnitude divide then re-sign; the most-negative / -1 case falls out
  // naturally as quotient 0x80..0 with remainder 0.
  always_comb begin
    neg_a    = is_signed & dividend[WIDTH-1];
    neg_b    = is_signed & divisor[WIDTH-1];
    mag_a    = neg_a ? -dividend : dividend;
    mag_b    = neg_b ? -divisor : divisor;
    div_zero = (divisor == '0);
    if (div_zero) begin
      mag_b = {{(WIDTH-1){1'b0}}, 1'b1};
    end
    q_mag = mag_a / mag_b;
    r_mag = mag_a % mag_b;
    quot  = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem   = neg_a ? -r_mag : r_mag;
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit with HI/LO registers. Results are computed at
// issue and held in a pending register until the busy countdown expires.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = MD_W,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             d_md_use,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_stall
);

  md_op_e           op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             signed_op;
  logic [2*WIDTH-1:0] ext_rs;
  logic [2*WIDTH-1:0] ext_rt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_zero;

  assign op = md_op_e'(md_op);
  assign signed_op = (op == MD_MULT) || (op == MD_DIV);

  // Sign/zero-extending to 2W lets one multiplier serve both mult and multu.
  assign ext_rs = signed_op ? {{WIDTH{rs_val[WIDTH-1]}}, rs_val} : {{WIDTH{1'b0}}, rs_val};
  assign ext_rt = signed_op ? {{WIDTH{rt_val[WIDTH-1]}}, rt_val} : {{WIDTH{1'b0}}, rt_val};
  assign prod   = ext_rs * ext_rt;

  md_divider #(.WIDTH(WIDTH)) u_div (
    .dividend (rs_val),
    .divisor  (rt_val),
    .is_signed(signed_op),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  assign busy     = (cnt != '0);
  assign md_stall = d_md_use & (busy | (start & is_arith(op)));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (flush) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (start) begin
      case (op)
        MD_MULT, MD_MULTU: begin
          pend_hi <= prod[2*WIDTH-1:WIDTH];
          pend_lo <= prod[WIDTH-1:0];
          cnt     <= CNT_W'(MULT_CYCLES);
        end
        MD_DIV, MD_DIVU: begin
          if (!div_zero) begin
            pend_hi <= rem;
            pend_lo <= quot;
            cnt     <= CNT_W'(DIV_CYCLES);
          end
        end
        MD_MTHI: hi <= rs_val;
        MD_MTLO: lo <= rs_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: a vector table for the single
// operations plus hand sequences for stall, flush and mid-operation reset.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        d_md_use;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_stall;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t vecs[13];

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .flush   (flush),
    .d_md_use(d_md_use),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .md_stall(md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The hazard unit must never issue into a busy unit; the bench never does.
  always @(posedge clk) begin
    if (!reset && start && busy) begin
      errors++;
      $display("FAIL start_while_busy: start=1 busy=1 at %0t", $time);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    start  = 1'b1;
    md_op  = v.op;
    rs_val = v.rs;
    rt_val = v.rt;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    for (int j = 0; j < v.cyc; j++) begin
      check({v.name, "_busy"}, {31'b0, busy}, 32'd1);
      check({v.name, "_hold_hi"}, hi, m_hi);
      check({v.name, "_hold_lo"}, lo, m_lo);
      check({v.name, "_nostall"}, {31'b0, md_stall}, 32'd0);
      @(negedge clk);
    end
    check({v.name, "_done"}, {31'b0, busy}, 32'd0);
    check({v.name, "_hi"}, hi, v.exp_hi);
    check({v.name, "_lo"}, lo, v.exp_lo);
    m_hi = v.exp_hi;
    m_lo = v.exp_lo;
  endtask

  initial begin
    vecs[0]  = '{"mult_neg",   3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{"multu_max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2]  = '{"div_neg",    3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{"div_ovf",    3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[4]  = '{"divu_zero",  3'd4, 32'h00000064, 32'h00000000, 32'h00000000, 32'h80000000, 0};
    vecs[5]  = '{"mthi",       3'd5, 32'h12345678, 32'h00000000, 32'h12345678, 32'h80000000, 0};
    vecs[6]  = '{"mtlo",       3'd6, 32'hCAFEBABE, 32'h00000000, 32'h12345678, 32'hCAFEBABE, 0};
    vecs[7]  = '{"divu_pos",   3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
    vecs[8]  = '{"div_negdiv", 3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[9]  = '{"mult_carry", 3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[10] = '{"op_none",    3'd0, 32'hDEADBEEF, 32'h00000005, 32'h00000001, 32'h00000000, 0};
    vecs[11] = '{"op_unused",  3'd7, 32'hDEADBEEF, 32'h00000005, 32'h00000001, 32'h00000000, 0};
    vecs[12] = '{"div_bothneg",3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};

    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0;
    flush = 1'b0; d_md_use = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", {31'b0, md_stall}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Stall covers the issue cycle and every busy cycle, then drops.
    d_md_use = 1'b1;
    #1;
    check("stall_idle", {31'b0, md_stall}, 32'd0);
    start = 1'b1; md_op = 3'd1; rs_val = 32'd2; rt_val = 32'd3;
    #1;
    check("stall_issue", {31'b0, md_stall}, 32'd1);
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    for (int j = 0; j < 5; j++) begin
      check("stall_busy", {31'b0, md_stall}, 32'd1);
      @(negedge clk);
    end
    check("stall_after", {31'b0, md_stall}, 32'd0);
    check("stall_hi", hi, 32'd0);
    check("stall_lo", lo, 32'd6);
    m_hi = 32'd0; m_lo = 32'd6;
    d_md_use = 1'b0;

    // Flush on busy cycle 2 discards the result permanently.
    start = 1'b1; md_op = 3'd1; rs_val = 32'd5; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);
    repeat (6) @(negedge clk);
    check("flush_late_hi", hi, m_hi);
    check("flush_late_lo", lo, m_lo);

    // Flush wins over a simultaneous start.
    flush = 1'b1; start = 1'b1; md_op = 3'd5; rs_val = 32'hAAAA5555;
    @(negedge clk);
    check("fs_mthi_hi", hi, m_hi);
    md_op = 3'd1; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clk);
    check("fs_mult_busy", {31'b0, busy}, 32'd0);
    flush = 1'b0; start = 1'b0; md_op = 3'd0;
    repeat (6) @(negedge clk);
    check("fs_mult_lo", lo, m_lo);

    // Reset on busy cycle 3 clears everything with no later commit.
    start = 1'b1; md_op = 3'd1; rs_val = 32'h11; rt_val = 32'h11;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    repeat (2) @(negedge clk);
    check("rstmid_busy_pre", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_busy", {31'b0, busy}, 32'd0);
    check("rstmid_hi", hi, 32'd0);
    check("rstmid_lo", lo, 32'd0);
    repeat (6) @(negedge clk);
    check("rstmid_late_lo", lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
